// File: rtl/icmp_echo_rx.sv
// icmp_echo_rx: receive side of an ICMP echo responder.
//
// Parses an ICMP byte stream, captures the echo header fields, stores the
// payload in a small byte buffer and validates the packet once its last byte
// has arrived. An accepted request raises o_trig_reply and holds its header
// fields and buffer until the transmit side signals i_reply_done. Anything
// else is discarded with a single o_drop pulse.
//
// Optional feature: define ICMP_RX_CSUM_EN to verify the ICMP checksum.
// Without it, no checksum logic exists and the checksum test always passes.
//
// After any reset the receiver does not know where it is in the stream, so
// it ignores bytes until it has seen one flagged i_icmp_last. The next valid
// byte after that starts a new packet.

module icmp_echo_rx #(
  parameter int         P_PL_AW    = 6,
  parameter logic [7:0] P_REQ_TYPE = 8'd8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [7:0]         i_icmp_data,
  input  logic [15:0]        i_icmp_len,
  input  logic               i_icmp_valid,
  input  logic               i_icmp_last,
  output logic               o_trig_reply,
  output logic [15:0]        o_trig_id,
  output logic [15:0]        o_trig_seq,
  output logic [15:0]        o_pl_len,
  input  logic [P_PL_AW-1:0] i_pl_rd_addr,
  output logic [7:0]         o_pl_rd_data,
  input  logic               i_reply_done,
  output logic               o_busy,
  output logic               o_drop
);

  localparam int          DEPTH    = 1 << P_PL_AW;
  // First byte index that no longer fits in the buffer (8 header bytes + DEPTH).
  localparam logic [16:0] PL_LIMIT = 17'(8 + DEPTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HDR     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_DISCARD = 3'd3;
  localparam logic [2:0] S_CHECK   = 3'd4;
  localparam logic [2:0] S_HOLD    = 3'd5;

  logic [2:0]  state;
  logic [15:0] cnt;          // index of the byte currently on the bus
  logic        resync;       // waiting for a packet boundary after reset

  // Header fields of the packet being parsed
  logic [7:0]  f_type;
  logic [7:0]  f_code;
  logic [15:0] f_id;
  logic [15:0] f_seq;

  // Results latched on the last byte, consumed in CHECK
  logic        len_ok;
  logic [15:0] rx_pl_len;

  logic        csum_ok;

  // Payload buffer
  logic [7:0]         mem [0:DEPTH-1];
  logic               wr_en;
  logic [P_PL_AW-1:0] wr_addr;
  logic               pl_fits;

  logic beat;
  logic beat_last;

  assign beat      = i_icmp_valid;
  assign beat_last = i_icmp_valid && i_icmp_last;

  // Payload byte k goes to address k-8; modulo arithmetic on the low bits
  // gives the same result without carrying unused upper bits around.
  assign pl_fits = ({1'b0, cnt} < PL_LIMIT);
  assign wr_addr = cnt[P_PL_AW-1:0] - P_PL_AW'(8);
  assign wr_en   = (state == S_PAYLOAD) && beat && pl_fits;

  assign o_busy  = (state == S_CHECK) || (state == S_HOLD);

  // Byte index counter: counts every valid byte, restarts after the last one.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; blocking = here would create ordering-dependent logic.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (beat) begin
      if (i_icmp_last) cnt <= '0;
      else             cnt <= cnt + 16'd1;
    end
  end

  // Stream alignment flag: set by reset, cleared at the next packet boundary.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      resync <= 1'b1;
    end else if (beat_last) begin
      resync <= 1'b0;
    end
  end

`ifdef ICMP_RX_CSUM_EN
  // Running one's-complement sum of big-endian 16-bit words. Even byte
  // indices supply the high byte, so an odd trailing byte is implicitly
  // padded with a zero low byte.
  logic [15:0] csum;
  logic [15:0] cs_word;
  logic [15:0] cs_base;
  logic [16:0] cs_add;

  assign cs_word = cnt[0] ? {8'h00, i_icmp_data} : {i_icmp_data, 8'h00};
  assign cs_base = (cnt == 16'd0) ? 16'h0000 : csum;
  assign cs_add  = {1'b0, cs_base} + {1'b0, cs_word};
  assign csum_ok = (csum == 16'hFFFF);

  // Accumulate with end-around carry; the fold can never carry twice.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      csum <= '0;
    end else if (beat) begin
      csum <= cs_add[15:0] + {15'd0, cs_add[16]};
    end
  end
`else
  assign csum_ok = 1'b1;
`endif

  // Payload buffer write port.
  // NOTE: the buffer has no reset; its contents are only meaningful below
  // o_pl_len while holding, so clearing it would add logic and buy nothing.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= i_icmp_data;
    end
  end

  // Registered payload read port, available in every state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_pl_rd_data <= '0;
    end else begin
      o_pl_rd_data <= mem[i_pl_rd_addr];
    end
  end

  // Receive FSM with header capture and the reply/drop pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_IDLE;
      f_type       <= '0;
      f_code       <= '0;
      f_id         <= '0;
      f_seq        <= '0;
      len_ok       <= 1'b0;
      rx_pl_len    <= '0;
      o_trig_reply <= 1'b0;
      o_trig_id    <= '0;
      o_trig_seq   <= '0;
      o_pl_len     <= '0;
      o_drop       <= 1'b0;
    end else begin
      o_trig_reply <= 1'b0;
      o_drop       <= 1'b0;

      case (state)
        S_IDLE: begin
          if (beat && !resync) begin
            if (cnt != 16'd0) begin
              // Joined mid-packet (reply released during a held packet).
              if (i_icmp_last) o_drop <= 1'b1;
              else             state  <= S_DISCARD;
            end else begin
              f_type <= i_icmp_data;
              if (i_icmp_last) o_drop <= 1'b1;
              else             state  <= S_HDR;
            end
          end
        end

        S_HDR: begin
          if (beat) begin
            case (cnt[2:0])
              3'd1:    f_code       <= i_icmp_data;
              3'd4:    f_id[15:8]   <= i_icmp_data;
              3'd5:    f_id[7:0]    <= i_icmp_data;
              3'd6:    f_seq[15:8]  <= i_icmp_data;
              3'd7:    f_seq[7:0]   <= i_icmp_data;
              default: ;
            endcase
            if (cnt == 16'd7) begin
              if (i_icmp_last) begin
                len_ok    <= (cnt + 16'd1 == i_icmp_len);
                rx_pl_len <= cnt - 16'd7;
                state     <= S_CHECK;
              end else begin
                state     <= S_PAYLOAD;
              end
            end else if (i_icmp_last) begin
              o_drop <= 1'b1;
              state  <= S_IDLE;
            end
          end
        end

        S_PAYLOAD: begin
          if (beat) begin
            if (!pl_fits) begin
              if (i_icmp_last) begin
                o_drop <= 1'b1;
                state  <= S_IDLE;
              end else begin
                state  <= S_DISCARD;
              end
            end else if (i_icmp_last) begin
              len_ok    <= (cnt + 16'd1 == i_icmp_len);
              rx_pl_len <= cnt - 16'd7;
              state     <= S_CHECK;
            end
          end
        end

        S_DISCARD: begin
          if (beat_last) begin
            o_drop <= 1'b1;
            state  <= S_IDLE;
          end
        end

        S_CHECK: begin
          if ((f_type == P_REQ_TYPE) && (f_code == 8'h00) && len_ok && csum_ok) begin
            o_trig_reply <= 1'b1;
            o_trig_id    <= f_id;
            o_trig_seq   <= f_seq;
            o_pl_len     <= rx_pl_len;
            state        <= S_HOLD;
          end else begin
            o_drop <= 1'b1;
            state  <= S_IDLE;
          end
        end

        S_HOLD: begin
          // Buffer and fields are owned by the transmit side; traffic is
          // counted but neither parsed nor stored.
          if (beat_last) o_drop <= 1'b1;
          if (i_reply_done) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
